angle_buttons: RTL and testbench
================================

# angle_buttons

Parametrised successor to the three-button angle controller. It holds NUM_CH independent angle accumulators, each stepped by its own push-button on every update strobe, and wraps modulo a full turn. Step size grows in powers of two while a button is held, and each channel has a synchronous zero command. It sits between the board push-button pins and the rotation/rendering pipeline that consumes the angles.

## Interface
- NUM_CH, 3: number of channels (buttons and angles).
- WIDTH, 32: angle width in bits, unsigned fixed point.
- STEP, 4915200: base step per update.
- MODULUS, 3019898880: wrap value, a full turn (360 << 23); angles are always < MODULUS.
- SYNC_STAGES, 2: flip-flops in each input synchroniser, minimum 2.
- ACCEL_UPDATES, 8: applied steps per acceleration level; 0 disables acceleration.
- MAX_SHIFT, 2: maximum acceleration level. Requires (STEP << MAX_SHIFT) < MODULUS and MODULUS < 2^WIDTH.

Ports:
- i_clk  in  1  the single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_buttons  in  NUM_CH  raw asynchronous button levels, 1 = pressed.
- i_reverse  in  1  raw asynchronous direction level, 1 = count down.
- i_update  in  1  synchronous step enable, not synchronised.
- i_zero  in  NUM_CH  synchronous per-channel clear, not synchronised.
- o_angle  out  NUM_CH*WIDTH  channel c is at [c*WIDTH +: WIDTH], registered.

## Operation
- Each i_buttons bit and i_reverse pass through a SYNC_STAGES-deep chain of flip-flops. Only the last stage (btn_s[c], rev_s) is used.
- Per channel the state is: angle (WIDTH bits), level (0..MAX_SHIFT) and hold_cnt (0..ACCEL_UPDATES-1).
- Current step = STEP << level. Arithmetic is done in WIDTH+1 bits.
- Priority on each edge, per channel:
  1. i_reset: all synchroniser stages, angles, levels and counters go to 0.
  2. i_zero[c]: angle, level and hold_cnt go to 0, regardless of i_update.
  3. btn_s[c]=0: angle holds; level and hold_cnt go to 0.
  4. btn_s[c]=1 and i_update=1: a step is applied.
  5. Otherwise all state holds.
- Step up (rev_s=0): if angle+step >= MODULUS, angle <= angle+step-MODULUS; else angle <= angle+step.
- Step down (rev_s=1): if angle < step, angle <= angle+MODULUS-step; else angle <= angle-step.
- Acceleration: on each applied step with ACCEL_UPDATES != 0:
  - if hold_cnt = ACCEL_UPDATES-1, then hold_cnt <= 0 and level <= min(level+1, MAX_SHIFT);
  - else hold_cnt increments.
  - The new level affects the next step only.
- Changing direction does not reset the acceleration.
- Channels are independent. They share rev_s and i_update. Simultaneous presses step every pressed channel on the same edge.

## Timing
- Reset values: o_angle = 0 on every channel. The sync chains, levels and counters are 0.
- Button latency: with i_update held high, a raw press sampled at edge k gives btn_s=1 after edge k+SYNC_STAGES-1. The first angle change is at edge k+SYNC_STAGES (3 edges after the press with defaults).
- Release: a raw release clears level and hold_cnt at the same edge where btn_s falls.
- Reverse latency equals button latency. A toggle sampled at edge k first affects the step at edge k+SYNC_STAGES. Steps already taken before then use the old direction.
- i_update and i_zero act at the first edge where they are sampled high (zero-cycle latency to state, one edge to o_angle).
- Reset during operation: the chains are cleared, so a button held through reset steps for the first time SYNC_STAGES+1 edges after the first edge with i_reset low. Rising-edge timing is counted the same way.
- Invariant, checkable on every edge: o_angle changes only if i_update was high on the previous edge, or i_zero[c] was high, or on reset.

## Test plan
- Reset and idle: hold i_reset 5 edges, then release; with i_update=1 and no buttons pressed for 10 edges → all angles stay 0.
- Ramp with acceleration: button0 held, i_update=1, i_reverse=0 → the first change occurs 3 edges after the press, to 4915200. Step 8 gives 39321600, step 9 gives 49152000, step 16 gives 117964800, step 17 gives 137625600 (step 4× STEP). Angles 1 and 2 stay 0.
- Down-wrap: i_reverse=1 settled, then press button1 with angle1=0 → 3014983680, then 3010068480. Toggle reverse to 0 → two more down steps, then 3014983680, then 0.
- Update gating and release: button2 held with i_update pulsed every 4th edge → exactly one step per pulse. hold_cnt advances only on pulses. Releasing for one synced cycle restores step 4915200.
- Zero priority: i_zero[0] asserted on the same edge as an applied step on angle0 = 137625600 → angle0 = 0. The next step is +4915200.
- Reset mid-ramp: assert i_reset for 1 edge during a level-2 ramp with the button held → all angles 0. The first step comes 3 edges after reset falls, with size 4915200.

Source files
------------

// File: rtl/angle_buttons.sv
// Multi-channel push-button angle accumulator with modular wrap and hold-to-accelerate stepping.
// Buttons and direction are synchronised; update and zero strobes are already in the clk domain.
module angle_buttons #(
  parameter int              NUM_CH        = 3,
  parameter int              WIDTH         = 32,
  parameter longint unsigned STEP          = 64'd4915200,
  parameter longint unsigned MODULUS       = 64'd3019898880,
  parameter int              SYNC_STAGES   = 2,
  parameter int              ACCEL_UPDATES = 8,
  parameter int              MAX_SHIFT     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH-1:0]       i_buttons,
  input  logic                    i_reverse,
  input  logic                    i_update,
  input  logic [NUM_CH-1:0]       i_zero,
  output logic [NUM_CH*WIDTH-1:0] o_angle
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int LVL_W  = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
  localparam int CNT_W  = (ACCEL_UPDATES > 1) ? $clog2(ACCEL_UPDATES) : 1;
  localparam bit ACCEL_EN = (ACCEL_UPDATES != 0);

  localparam logic [WIDTH:0]     MOD_X    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]     STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [LVL_W-1:0]   LVL_MAX  = LVL_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0]   CNT_LAST = (ACCEL_UPDATES > 0) ? CNT_W'(ACCEL_UPDATES - 1) : '0;

  // Top bit of each stage carries the direction level, the rest the buttons.
  logic [NUM_CH:0] sync_q [SYNC_N];
  logic [NUM_CH-1:0] btn_s;
  logic              rev_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_N; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {i_reverse, i_buttons};
      for (int s = 1; s < SYNC_N; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign btn_s = sync_q[SYNC_N-1][NUM_CH-1:0];
  assign rev_s = sync_q[SYNC_N-1][NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] angle;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] hold_cnt;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   angle_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] next_angle;

    // One extra bit keeps angle+step and angle+MODULUS from overflowing before the wrap.
    always_comb begin
      step    = STEP_X << level;
      angle_x = {1'b0, angle};
      sum_up  = angle_x + step;
      next_angle = '0;
      if (rev_s) begin
        if (angle_x < step) next_angle = WIDTH'(angle_x + MOD_X - step);
        else                next_angle = WIDTH'(angle_x - step);
      end else begin
        if (sum_up >= MOD_X) next_angle = WIDTH'(sum_up - MOD_X);
        else                 next_angle = WIDTH'(sum_up);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset || i_zero[c]) begin
        angle    <= '0;
        level    <= '0;
        hold_cnt <= '0;
      end else if (!btn_s[c]) begin
        level    <= '0;
        hold_cnt <= '0;
      end else if (i_update) begin
        angle <= next_angle;
        if (ACCEL_EN) begin
          if (hold_cnt == CNT_LAST) begin
            hold_cnt <= '0;
            if (level != LVL_MAX) level <= level + LVL_W'(1);
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
      end
    end

    assign o_angle[c*WIDTH +: WIDTH] = angle;
  end

endmodule

// File: tb/tb_angle_buttons.sv
// Directed bench for angle_buttons: the driver queues hand-computed angles tagged with the
// edge at which they must appear; a monitor pops and compares them, and checks hold-when-idle.
module tb_angle_buttons;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       buttons = '0;
  logic                    reverse = 1'b0;
  logic                    update  = 1'b0;
  logic [NUM_CH-1:0]       zero    = '0;
  logic [NUM_CH*WIDTH-1:0] angle;

  angle_buttons dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_buttons (buttons),
    .i_reverse (reverse),
    .i_update  (update),
    .i_zero    (zero),
    .o_angle   (angle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic expect_at(input int n, input int ch, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + n; e.ch = ch; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each rising edge, while inputs are still stable.
  initial begin
    logic [NUM_CH*WIDTH-1:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s: expectation for edge %0d not checked in time", e.name, e.cyc);
        end else if (angle[e.ch*WIDTH +: WIDTH] !== e.val) begin
          bad++;
          $display("FAIL %s: edge %0d ch%0d angle=%0d expected=%0d",
                   e.name, cyc, e.ch, angle[e.ch*WIDTH +: WIDTH], e.val);
        end
      end
      if (cyc > 1 && !(update || (|zero) || rst)) begin
        total++;
        if (angle !== last) begin
          bad++;
          $display("FAIL hold_when_idle: edge %0d angle=%h previous=%h", cyc, angle, last);
        end
      end
      last = angle;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    // Reset and idle
    tick(4);
    for (int c = 0; c < NUM_CH; c++) expect_at(1, c, 32'd0, "reset");
    tick(1);
    rst = 1'b0;
    update = 1'b1;
    for (int c = 0; c < NUM_CH; c++) expect_at(1, c, 32'd0, "idle_first");
    for (int c = 0; c < NUM_CH; c++) expect_at(10, c, 32'd0, "idle_last");
    tick(10);

    // Ramp with acceleration on channel 0, then zero wins over a step
    buttons[0] = 1'b1;
    expect_at(2,  0, 32'd0,         "ramp_latency");
    expect_at(3,  0, 32'd4915200,   "ramp_step1");
    expect_at(10, 0, 32'd39321600,  "ramp_step8");
    expect_at(11, 0, 32'd49152000,  "ramp_step9");
    expect_at(18, 0, 32'd117964800, "ramp_step16");
    expect_at(19, 0, 32'd137625600, "ramp_step17");
    expect_at(19, 1, 32'd0,         "ramp_ch1_idle");
    expect_at(19, 2, 32'd0,         "ramp_ch2_idle");
    tick(19);
    zero[0] = 1'b1;
    expect_at(1, 0, 32'd0, "zero_priority");
    tick(1);
    zero[0] = 1'b0;
    expect_at(1, 0, 32'd4915200, "zero_next_step");
    tick(1);
    update  = 1'b0;
    buttons = '0;
    tick(4);

    // Down-wrap on channel 1, direction flips mid-run
    reverse = 1'b1;
    tick(3);
    buttons[1] = 1'b1;
    update = 1'b1;
    expect_at(3, 1, 32'd3014983680, "down_wrap");
    expect_at(4, 1, 32'd3010068480, "down_step2");
    tick(4);
    reverse = 1'b0;
    expect_at(1, 1, 32'd3005153280, "rev_lag1");
    expect_at(2, 1, 32'd3000238080, "rev_lag2");
    expect_at(3, 1, 32'd3005153280, "rev_up1");
    expect_at(4, 1, 32'd3010068480, "rev_up2");
    expect_at(5, 1, 32'd3014983680, "rev_up3");
    expect_at(6, 1, 32'd0,          "up_wrap");
    expect_at(6, 0, 32'd4915200,    "down_ch0_hold");
    tick(6);
    update  = 1'b0;
    buttons = '0;
    tick(2);

    // Update gating on channel 2: acceleration counts pulses, not held cycles
    buttons[2] = 1'b1;
    tick(3);
    for (int p = 0; p < 9; p++) begin
      update = 1'b1;
      if (p == 0) expect_at(1, 2, 32'd4915200,  "gate_pulse1");
      if (p == 7) expect_at(1, 2, 32'd39321600, "gate_pulse8");
      if (p == 8) expect_at(1, 2, 32'd49152000, "gate_pulse9");
      tick(1);
      update = 1'b0;
      tick(3);
    end
    buttons[2] = 1'b0;
    tick(1);
    buttons[2] = 1'b1;
    tick(3);
    update = 1'b1;
    expect_at(1, 2, 32'd54067200, "release_restores_base");
    expect_at(1, 0, 32'd4915200,  "gate_ch0_hold");
    expect_at(1, 1, 32'd0,        "gate_ch1_hold");
    tick(1);
    update  = 1'b0;
    buttons = '0;
    tick(3);

    // Reset in the middle of a level-2 ramp on channel 0
    buttons[0] = 1'b1;
    update = 1'b1;
    expect_at(18, 0, 32'd122880000, "rr_step16");
    expect_at(19, 0, 32'd142540800, "rr_step17");
    expect_at(20, 0, 32'd162201600, "rr_step18");
    expect_at(20, 2, 32'd54067200,  "rr_ch2_hold");
    tick(20);
    rst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) expect_at(1, c, 32'd0, "reset_mid_ramp");
    tick(1);
    rst = 1'b0;
    expect_at(2, 0, 32'd0,       "post_reset_latency");
    expect_at(3, 0, 32'd4915200, "post_reset_base_step");
    tick(3);
    update  = 1'b0;
    buttons = '0;
    tick(3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
